fib_call_responder: RTL
=======================

Name: fib_call_responder

Overview:
- Callee end of the ready/accept/valid call protocol that test benches and caller FSMs use to invoke a function block.
- Accepts an argument n, computes the Fibonacci number F(n) iteratively and presents it as a held result until the caller accepts it.
- Adds signed-overflow reporting and back-to-back call support.
- Sits under any caller FSM, or under a bench that drives fib_ready, samples fib_valid and returns fib_accept.

Parameters:
- DATA_W, 32, width of argument and result (two's complement).
- CNT_W, 32, width of the internal iteration counter; must be >= DATA_W.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low (0 = reset).
- fib_ready  in  1  call strobe; one-cycle pulse; fib_in_n is sampled on the same edge.
- fib_accept  in  1  caller has taken the result; one-cycle pulse.
- fib_valid  out  1  result available; held until fib_accept is sampled.
- fib_in_n  in  DATA_W  signed argument n.
- fib_out_0  out  DATA_W  signed result F(n) mod 2^DATA_W; stable while fib_valid = 1.
- fib_ovf  out  1  at least one addition in this call exceeded the signed range; valid with fib_valid.
- fib_busy  out  1  high in CALC and DONE.

Behaviour:
- Reset (rst = 0, any time, asynchronous):
  - state = IDLE.
  - fib_valid = 0, fib_out_0 = 0, fib_ovf = 0, fib_busy = 0.
  - Internal a = 0, b = 1, i = 0, n_q = 0.
- Reset mid-call aborts the call. No result is produced, and the caller must re-issue after reset releases.
- States:
  - IDLE: on fib_ready = 1, latch n_q = fib_in_n, set a = 0, b = 1, i = 0, clear ovf_q, go to CALC. fib_accept is ignored.
  - CALC: if n_q <= 0 or i == n_q, load fib_out_0 = a and fib_ovf = ovf_q, go to DONE. Otherwise update a <= b, b <= a + b (wrapping at DATA_W bits), i <= i + 1. Set ovf_q if the signed add a + b overflows. fib_ready is ignored.
  - DONE: fib_valid = 1; fib_out_0 and fib_ovf are held constant.
    - On fib_accept = 1 with fib_ready = 0: go to IDLE; fib_valid falls the next cycle.
    - On fib_accept = 1 with fib_ready = 1: back-to-back call. Latch the new fib_in_n, reinitialise a, b, i and ovf_q, go directly to CALC; fib_valid falls.
    - On fib_ready = 1 with fib_accept = 0: ignored; no queueing.
- Latency:
  - Edge E0 samples fib_ready. fib_valid is high after edge E0 + max(n, 0) + 1.
  - n = 0: 1 cycle; n = 3: 4 cycles.
- Negative n: treated as 0; result 0, ovf 0, latency 1.
- fib_out_0 is registered and changes only on CALC-to-DONE.
- fib_valid and fib_busy are registered outputs decoded from state; no combinational path from any input to any output.
- ovf_q tracks overflow of a + b only.
  - b may wrap one iteration before it becomes a.
  - The flag reflects wrap of any computed term up to F(n+1). This is documented behaviour: fib_ovf may be set when F(n) itself fits but F(n+1) does not.

Test Plan:
- Reset release, then calls n = 0, 1, 2, 3, each with ready pulse, wait valid, accept pulse.
  - fib_out_0 = 0, 1, 1, 2.
  - valid at 1, 2, 3, 4 cycles after the ready edge.
  - fib_ovf = 0.
- n = 10 -> fib_out_0 = 55, valid 11 cycles after ready; hold accept low 5 extra cycles -> valid and out stay at 55; accept -> valid low next cycle.
- n = -5 -> fib_out_0 = 0, valid after 1 cycle, fib_ovf = 0.
- DATA_W = 32:
  - n = 46 -> 1836311903, fib_ovf = 1 (F(47) overflows).
  - n = 47 -> -1323752223, fib_ovf = 1.
  - n = 45 -> 1134903170, fib_ovf = 0.
- Back-to-back: in DONE with result 2 (n = 3), assert accept and ready together with n = 4.
  - fib_valid drops, then rises 5 cycles later with 3.
  - No idle cycle is inserted.
- Ready pulse with n = 7 during CALC of n = 20 -> ignored; result 6765. Then pull rst low mid-CALC of n = 30 -> outputs 0 immediately; next call with n = 5 -> 5.

Source files
------------

// File: rtl/fib_call_responder_if.sv
// Call-protocol bundle between a caller FSM (master) and the Fibonacci callee (slave).
// The caller drives the ready/accept strobes and the argument; the callee returns the result.
interface fib_call_responder_if #(
    parameter int unsigned DATA_W = 32
);
    logic                     fib_ready;
    logic                     fib_accept;
    logic signed [DATA_W-1:0] fib_in_n;
    logic                     fib_valid;
    logic signed [DATA_W-1:0] fib_out_0;
    logic                     fib_ovf;
    logic                     fib_busy;

    modport master (
        output fib_ready, fib_accept, fib_in_n,
        input  fib_valid, fib_out_0, fib_ovf, fib_busy
    );

    modport slave (
        input  fib_ready, fib_accept, fib_in_n,
        output fib_valid, fib_out_0, fib_ovf, fib_busy
    );
endinterface

// File: rtl/fib_call_responder.sv
// Callee for the ready/accept/valid call protocol: computes F(n) iteratively,
// holds the result until it is accepted, and reports signed overflow of any computed term.
module fib_call_responder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    fib_call_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic signed [DATA_W-1:0] a_q, a_d;
    logic signed [DATA_W-1:0] b_q, b_d;
    logic        [CNT_W-1:0]  i_q, i_d;
    logic signed [DATA_W-1:0] n_q, n_d;
    logic                     ovf_q, ovf_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic                     ovf_out_q, ovf_out_d;
    logic                     valid_q, valid_d;
    logic                     busy_q, busy_d;

    logic signed [DATA_W-1:0] sum_c;
    logic                     add_ovf_c;
    logic                     start_c;
    logic                     finish_c;

    // Wrapping add; overflow when both operands share a sign the sum does not.
    assign sum_c     = a_q + b_q;
    assign add_ovf_c = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum_c[DATA_W-1] != a_q[DATA_W-1]);
    // Non-positive n finishes immediately with a = 0.
    assign finish_c  = n_q[DATA_W-1] || (n_q == '0) || (i_q == CNT_W'($unsigned(n_q)));

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        i_d       = i_q;
        n_d       = n_q;
        ovf_d     = ovf_q;
        out_d     = out_q;
        ovf_out_d = ovf_out_q;
        start_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.fib_ready) start_c = 1'b1;
            end
            CALC: begin
                if (finish_c) begin
                    out_d     = a_q;
                    ovf_out_d = ovf_q;
                    state_d   = DONE;
                end else begin
                    a_d = b_q;
                    b_d = sum_c;
                    i_d = i_q + CNT_W'(1);
                    if (add_ovf_c) ovf_d = 1'b1;
                end
            end
            DONE: begin
                // A ready without accept is dropped; with accept it starts the next call directly.
                if (bus.fib_accept) begin
                    if (bus.fib_ready) start_c = 1'b1;
                    else               state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_c) begin
            n_d     = bus.fib_in_n;
            a_d     = '0;
            b_d     = DATA_W'(1);
            i_d     = '0;
            ovf_d   = 1'b0;
            state_d = CALC;
        end

        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= DATA_W'(1);
            i_q       <= '0;
            n_q       <= '0;
            ovf_q     <= 1'b0;
            out_q     <= '0;
            ovf_out_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            i_q       <= i_d;
            n_q       <= n_d;
            ovf_q     <= ovf_d;
            out_q     <= out_d;
            ovf_out_q <= ovf_out_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.fib_valid = valid_q;
    assign bus.fib_busy  = busy_q;
    assign bus.fib_out_0 = out_q;
    assign bus.fib_ovf   = ovf_out_q;

endmodule
